// File: rtl/seq_mul_param_if.sv
// Request/response bundle between the control unit and the iterative multiplier.
// The master owns start and operands; the multiplier drives status and product.
interface seq_mul_param_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mul_param.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per RUN cycle.
// Signed operands run as magnitudes; the sign is reapplied when the product is written.

// One partial-product row: gated multiplicand at a fixed bit offset.
module seq_mul_pp_row #(
  parameter int W2 = 64,
  parameter int SH = 0
) (
  input  logic          bit_i,
  input  logic [W2-1:0] mcand,
  output logic [W2-1:0] pp
);
  assign pp = bit_i ? (mcand << SH) : '0;
endmodule

module seq_mul_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  seq_mul_param_if.slave  bus
);
  localparam int N   = WIDTH / BITS_PER_CYCLE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int W2  = 2 * WIDTH;
  localparam int BPC = BITS_PER_CYCLE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [W2-1:0]    mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [W2-1:0]    acc_q,     acc_d;
  logic             neg_q,     neg_d;
  logic [W2-1:0]    product_q, product_d;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = bus.is_signed & bus.op_a[WIDTH-1];
    b_neg = bus.is_signed & bus.op_b[WIDTH-1];
    a_mag = a_neg ? -bus.op_a : bus.op_a;
    b_mag = b_neg ? -bus.op_b : bus.op_b;
  end

  logic [BPC-1:0][W2-1:0] pp;
  logic [W2-1:0]          step_sum;
  logic [W2-1:0]          acc_nxt;

  for (genvar g = 0; g < BPC; g++) begin : g_row
    seq_mul_pp_row #(
      .W2 (W2),
      .SH (g)
    ) u_row (
      .bit_i (mplier_q[g]),
      .mcand (mcand_q),
      .pp    (pp[g])
    );
  end

  always_comb begin
    step_sum = '0;
    for (int k = 0; k < BPC; k++) step_sum = step_sum + pp[k];
    acc_nxt = acc_q + step_sum;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      S_RUN: begin
        // start is deliberately ignored here; operands stay frozen until DONE.
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << BPC;
        mplier_d = mplier_q >> BPC;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          product_d = neg_q ? -acc_nxt : acc_nxt;
        end
      end
      default: begin
        // IDLE and DONE both accept, so back-to-back ops skip the idle cycle.
        state_d = S_IDLE;
        if (bus.start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mul_param.sv
// Randomized and directed bench for seq_mul_param: one 32-bit instance plus a
// 16-bit sweep across 1, 2 and 4 bits per cycle, all checked against integer arithmetic.
module tb_seq_mul_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_mul_param_if #(.WIDTH(32)) b32 ();
  seq_mul_param_if #(.WIDTH(16)) b16_1 ();
  seq_mul_param_if #(.WIDTH(16)) b16_2 ();
  seq_mul_param_if #(.WIDTH(16)) b16_4 ();

  seq_mul_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u32   (.clk(clk), .reset(reset), .bus(b32));
  seq_mul_param #(.WIDTH(16), .BITS_PER_CYCLE(1)) u16_1 (.clk(clk), .reset(reset), .bus(b16_1));
  seq_mul_param #(.WIDTH(16), .BITS_PER_CYCLE(2)) u16_2 (.clk(clk), .reset(reset), .bus(b16_2));
  seq_mul_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) u16_4 (.clk(clk), .reset(reset), .bus(b16_4));

  function automatic logic [63:0] model32(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] model16(logic [15:0] a, logic [15:0] b, logic s);
    int sa, sb;
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      return 32'(sa * sb);
    end
    return {16'b0, a} * {16'b0, b};
  endfunction

  // Issue one op on the 32-bit DUT from a negedge; returns product, edges to done
  // (acceptance edge counts as 1, -1 on timeout) and busy cycles seen.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      output logic [63:0] p, output int lat, output int bcnt);
    b32.op_a = a; b32.op_b = b; b32.is_signed = s; b32.start = 1'b1;
    lat = -1; bcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      b32.start = 1'b0;
      if (b32.busy) bcnt++;
      if (b32.done) begin lat = k; break; end
    end
    p = b32.product;
  endtask

  task automatic test_reset;
    logic [65:0] snap;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (b32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b32.busy); end
    checks++; if (b32.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", b32.done); end
    checks++; if (b32.product !== 64'h0) begin errors++; $display("FAIL reset_product got %h want 0", b32.product); end
    reset = 1'b0;
    snap = {1'b0, 1'b0, 64'h0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({b32.busy, b32.done, b32.product} !== snap) begin
        errors++; $display("FAIL idle_hold cycle %0d got %h want %h", i, {b32.busy, b32.done, b32.product}, snap);
      end
    end
  endtask

  task automatic test_unsigned_max;
    logic [63:0] p; int lat, bc;
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL umax_latency got %0d want 33", lat); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL umax_busy_cycles got %0d want 32", bc); end
    checks++; if (p !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL umax_product got %h want FFFFFFFE00000001", p); end
    @(negedge clk);
    checks++; if (b32.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", b32.done); end
  endtask

  task automatic test_signed;
    logic [31:0] ta [4] = '{32'hFFFFFFFF, 32'd7,        32'h80000000, 32'd0};
    logic [31:0] tb [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFB};
    logic [63:0] te [4] = '{64'd1, 64'hFFFFFFFFFFFFFFEB, 64'h4000000000000000, 64'd0};
    logic [63:0] p; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      op32(ta[i], tb[i], 1'b1, p, lat, bc);
      checks++; if (p !== te[i]) begin errors++; $display("FAIL signed_%0d product got %h want %h", i, p, te[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL signed_%0d latency got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_random32;
    logic [31:0] a, b; logic s; logic [63:0] p, exp; int lat, bc;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      exp = model32(a, b, s);
      op32(a, b, s, p, lat, bc);
      checks++;
      if (p !== exp || lat !== 33) begin
        errors++; $display("FAIL rand32 a=%h b=%h s=%b got %h lat %0d want %h lat 33", a, b, s, p, lat, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, lat2; logic stable; logic busy_first;
    b32.op_a = 32'd6; b32.op_b = 32'd7; b32.is_signed = 1'b0; b32.start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) b32.start = 1'b0;
      if (k == 5) begin b32.start = 1'b1; b32.op_a = 32'd9; b32.op_b = 32'd9; b32.is_signed = 1'b1; end
      if (k == 6) b32.start = 1'b0;
      if (b32.done) begin lat = k; break; end
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_start latency got %0d want 33", lat); end
    checks++; if (b32.product !== 64'd42) begin errors++; $display("FAIL ignore_start product got %0d want 42", b32.product); end
    // Start on the done cycle itself.
    b32.op_a = 32'd3; b32.op_b = 32'd5; b32.is_signed = 1'b0; b32.start = 1'b1;
    lat2 = -1; stable = 1'b1; busy_first = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin b32.start = 1'b0; busy_first = b32.busy; end
      if (b32.done) begin lat2 = k; break; end
      if (b32.product !== 64'd42) stable = 1'b0;
    end
    checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL b2b_no_gap busy got %b want 1", busy_first); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL b2b_product_hold got unstable want 42 held"); end
    checks++; if (lat2 !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat2); end
    checks++; if (b32.product !== 64'd15) begin errors++; $display("FAIL b2b_product got %0d want 15", b32.product); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic seen_done; logic [63:0] p; int lat, bc;
    b32.op_a = 32'd11; b32.op_b = 32'd13; b32.is_signed = 1'b0; b32.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      b32.start = 1'b0;
    end
    checks++; if (b32.busy !== 1'b1) begin errors++; $display("FAIL midop_running busy got %b want 1", b32.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (b32.busy !== 1'b0) begin errors++; $display("FAIL midop_busy got %b want 0", b32.busy); end
    checks++; if (b32.product !== 64'h0) begin errors++; $display("FAIL midop_product got %h want 0", b32.product); end
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b32.done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL midop_no_done got %b want 0", seen_done); end
    op32(32'd100, 32'hFFFFFFF9, 1'b1, p, lat, bc);
    checks++;
    if (p !== model32(32'd100, 32'hFFFFFFF9, 1'b1) || lat !== 33) begin
      errors++; $display("FAIL midop_recover got %h lat %0d want %h lat 33", p, lat, model32(32'd100, 32'hFFFFFFF9, 1'b1));
    end
  endtask

  task automatic test_sweep16;
    logic [15:0] a, b; logic s; logic [31:0] exp;
    int lat [3]; logic [31:0] p [3];
    int want [3] = '{17, 9, 5};
    for (int i = 0; i < 24; i++) begin
      case (i)
        0: begin a = 16'h8000; b = 16'h8000; s = 1'b1; end
        1: begin a = 16'hFFFF; b = 16'hFFFF; s = 1'b0; end
        2: begin a = 16'h0000; b = 16'h8001; s = 1'b1; end
        3: begin a = 16'h7FFF; b = 16'h8000; s = 1'b1; end
        default: begin a = 16'($urandom); b = 16'($urandom); s = 1'($urandom_range(0, 1)); end
      endcase
      exp = model16(a, b, s);
      b16_1.op_a = a; b16_1.op_b = b; b16_1.is_signed = s; b16_1.start = 1'b1;
      b16_2.op_a = a; b16_2.op_b = b; b16_2.is_signed = s; b16_2.start = 1'b1;
      b16_4.op_a = a; b16_4.op_b = b; b16_4.is_signed = s; b16_4.start = 1'b1;
      lat = '{-1, -1, -1};
      p = '{32'h0, 32'h0, 32'h0};
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        b16_1.start = 1'b0; b16_2.start = 1'b0; b16_4.start = 1'b0;
        if (b16_1.done && lat[0] < 0) begin lat[0] = k; p[0] = b16_1.product; end
        if (b16_2.done && lat[1] < 0) begin lat[1] = k; p[1] = b16_2.product; end
        if (b16_4.done && lat[2] < 0) begin lat[2] = k; p[2] = b16_4.product; end
      end
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (p[j] !== exp || lat[j] !== want[j]) begin
          errors++;
          $display("FAIL sweep16 cfg %0d a=%h b=%h s=%b got %h lat %0d want %h lat %0d", j, a, b, s, p[j], lat[j], exp, want[j]);
        end
      end
    end
  endtask

  initial begin
    b32.start = 1'b0; b32.is_signed = 1'b0; b32.op_a = '0; b32.op_b = '0;
    b16_1.start = 1'b0; b16_1.is_signed = 1'b0; b16_1.op_a = '0; b16_1.op_b = '0;
    b16_2.start = 1'b0; b16_2.is_signed = 1'b0; b16_2.op_a = '0; b16_2.op_b = '0;
    b16_4.start = 1'b0; b16_4.is_signed = 1'b0; b16_4.op_a = '0; b16_4.op_b = '0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_random32();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
